imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a byte stream (e.g. from UART RX),

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a length-prefixed byte stream into big-endian IMEM words, then zero-fills the rest
// Optional IMEM_LOADER_CKSUM_EN: a trailing checksum byte (sum of payload mod 256) gates the fill.
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int IW = $clog2(MEM_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    len_hi;
    logic [15:0]   len;
    logic [15:0]   len_rx;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [1:0]    byte_cnt;
    logic [23:0]   shreg;
    logic          accept, word_done, last_word, fill_wr, load_start;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]    cksum;
`endif

    assign len_rx   = {len_hi, in_data};
    assign idx_inc  = idx + IW'(1);
    assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHK);
    assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) ||
                      (state == S_CHK)    || (state == S_FILL);
    assign cpu_hold = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    always_comb begin
        state_nx   = state;
        fill_wr    = 1'b0;
        load_start = 1'b0;
        accept     = in_valid && in_ready;
        word_done  = accept && (state == S_DATA) && (byte_cnt == 2'd3);
        last_word  = (32'(idx_inc) == 32'(len));
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nx   = S_LEN_HI;
                    load_start = 1'b1;
                end
            end
            S_LEN_HI: if (accept) state_nx = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_rx) > MEM_SIZE)
                        state_nx = S_ERR;
                    else if (len_rx == 16'd0)
`ifdef IMEM_LOADER_CKSUM_EN
                        state_nx = S_CHK;
`else
                        state_nx = S_FILL;
`endif
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (word_done && last_word)
`ifdef IMEM_LOADER_CKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = (32'(idx_inc) == MEM_SIZE) ? S_DONE : S_FILL;
`endif
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (accept) begin
                    if (in_data != cksum)
                        state_nx = S_ERR;
                    else
                        state_nx = (32'(idx) == MEM_SIZE) ? S_DONE : S_FILL;
                end
`else
                state_nx = S_ERR;
`endif
            end
            S_FILL: begin
                if (32'(idx) == MEM_SIZE)
                    state_nx = S_DONE;
                else
                    fill_wr = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Write port is registered: a word appears the cycle after its last byte (or fill slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi   <= 8'd0;
            len      <= 16'd0;
            idx      <= '0;
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
            wr_en    <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (load_start) begin
                idx      <= '0;
                byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum    <= 8'd0;
`endif
            end
            if (accept && state == S_LEN_HI) len_hi <= in_data;
            if (accept && state == S_LEN_LO) len <= len_rx;
            if (accept && state == S_DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= {shreg[15:0], in_data};
`ifdef IMEM_LOADER_CKSUM_EN
                cksum    <= cksum + in_data;
`endif
            end
            if (word_done || fill_wr) begin
                wr_en   <= 1'b1;
                wr_addr <= BASE_ADDR + (32'(idx) << 2);
                wr_data <= word_done ? {shreg, in_data} : 32'd0;
                idx     <= idx_inc;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven and scoreboard bench for imem_loader
module tb_imem_loader;
    localparam int          MEM  = 512;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, cpu_hold, busy, done, err;
    logic [31:0] wr_addr, wr_data;

    imem_loader #(.MEM_SIZE(MEM), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        contig;
    } exp_t;

    typedef struct {
        int          nb;
        logic [79:0] bytes;
        int          gap;
        bit          exp_err;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] stim[$];
    vec_t       vecs[4];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    int         cksum_bias = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write act=%h/%h exp=none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                if (e.contig) chk("fill_per_cycle", 32'(cyc - last_wr_cyc), 32'd1);
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk("in_ready_rx", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic run_load(input int gap, input bit exp_err);
        int          n, t;
        logic [31:0] w;
        logic [7:0]  sum;
        n   = {stim[0], stim[1]};
        sum = 8'd0;
        w   = 32'd0;
        pulse_start();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], gap);
            if (i >= 2) begin
                sum = sum + stim[i];
                w   = {w[23:0], stim[i]};
                if ((i - 2) % 4 == 3)
                    exp_q.push_back('{BASE + 32'(4 * ((i - 2) / 4)), w, 1'b0});
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        if (n <= MEM) send_byte(sum + 8'(cksum_bias), gap);
`endif
        @(negedge clk); in_valid = 1'b0;
        if (!exp_err)
            for (int k = n; k < MEM; k++)
                exp_q.push_back('{BASE + 32'(4 * k), 32'd0, k > n});
        t = 0;
        while (!(done || err) && t < 3000) begin @(negedge clk); t++; end
        chk("finish_in_time", 32'(t < 3000), 32'd1);
        repeat (2) @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, !exp_err});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, exp_err});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{nb: 10, bytes: 80'h0002_2004_0020_2005_0000, gap: 0, exp_err: 1'b0};
        vecs[1] = '{nb: 2,  bytes: 80'h0000_0000_0000_0000_0000, gap: 0, exp_err: 1'b0};
        vecs[2] = '{nb: 2,  bytes: 80'h0201_0000_0000_0000_0000, gap: 0, exp_err: 1'b1};
        vecs[3] = '{nb: 10, bytes: 80'h0002_2004_0020_2005_0000, gap: 2, exp_err: 1'b0};

        #3 reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            stim.delete();
            for (int i = 0; i < vecs[v].nb; i++)
                stim.push_back(vecs[v].bytes[79 - 8 * i -: 8]);
            run_load(vecs[v].gap, vecs[v].exp_err);
        end

        // Reset in the middle of a word: nothing written, outputs drop at once.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h04, 0);
        @(negedge clk); in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {26'd0, in_ready, wr_en, cpu_hold, busy, done, err}, 32'd0);
        chk("mid_rst_wr_addr", wr_addr, BASE);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stim.delete();
        stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, 1'b0);

        // Image exactly fills the memory: no fill phase.
        stim.delete();
        stim.push_back(8'h02);
        stim.push_back(8'h00);
        for (int i = 0; i < 4 * MEM; i++) stim.push_back(8'($urandom_range(0, 255)));
        run_load(0, 1'b0);

`ifdef IMEM_LOADER_CKSUM_EN
        stim.delete();
        stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load(0, 1'b0);
        cksum_bias = 1;
        run_load(0, 1'b1);
        cksum_bias = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
